// File: rtl/xram_responder.sv
// Byte-wide XRAM target shared by the 8051 core and the AES accelerator.
// Define XRAM_RR_ARB_EN for round-robin arbitration (default: CPU priority).
module xram_responder #(
    parameter int          MEM_AW      = 12,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [15:0] CPU_LIMIT   = 16'hff00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_in,
    output logic [7:0]  cpu_data_out,
    input  logic        cpu_wr,
    input  logic        cpu_stb,
    output logic        cpu_ack,
    input  logic [15:0] acc_xram_addr,
    input  logic [7:0]  acc_xram_data_out,
    output logic [7:0]  acc_xram_data_in,
    input  logic        acc_xram_wr,
    input  logic        acc_xram_stb,
    output logic        acc_xram_ack,
    output logic        busy,
    output logic        grant
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                grant_q, grant_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                acc_ack_q, acc_ack_d;
    logic [7:0]          cpu_rd_q, cpu_rd_d;
    logic [7:0]          acc_rd_q, acc_rd_d;
    logic                busy_q, busy_d;

    logic [7:0]          mem_q [0:(1<<MEM_AW)-1];

    logic                cpu_req;
    logic                acc_req;
    logic                any_req;
    logic                win;
    logic                gnt_stb;
    logic                unused_addr;

    assign cpu_req = cpu_stb && (cpu_addr < CPU_LIMIT);
    assign acc_req = acc_xram_stb;
    assign any_req = cpu_req || acc_req;
    assign gnt_stb = grant_q ? acc_xram_stb : cpu_stb;

    // Upper address bits only alias; fold them so nothing is left dangling.
    assign unused_addr = ^acc_xram_addr;

`ifdef XRAM_RR_ARB_EN
    logic last_q, last_d;

    always_comb begin
        if (cpu_req && acc_req) begin
            win = ~last_q;
        end else begin
            win = acc_req;
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == S_IDLE && any_req) begin
            last_d = win;
        end
    end

    // Last owner starts as the accelerator so the CPU wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign win = !cpu_req;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                if (!gnt_stb) begin
                    state_d = S_IDLE;
                end else if (cnt_q <= 4'd1) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        grant_d   = grant_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        cpu_rd_d  = cpu_rd_q;
        acc_rd_d  = acc_rd_q;
        cpu_ack_d = 1'b0;
        acc_ack_d = 1'b0;

        if (state_q == S_IDLE && any_req) begin
            grant_d = win;
            cnt_d   = 4'(WAIT_CYCLES);
            if (win) begin
                addr_d  = acc_xram_addr[MEM_AW-1:0];
                wr_d    = acc_xram_wr;
                wdata_d = acc_xram_data_out;
            end else begin
                addr_d  = cpu_addr[MEM_AW-1:0];
                wr_d    = cpu_wr;
                wdata_d = cpu_data_in;
            end
        end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end

        // Read data is captured on entry to ACK so it is valid with the ack.
        if (state_d == S_ACK) begin
            cpu_ack_d = !grant_d;
            acc_ack_d = grant_d;
            if (!wr_d) begin
                if (grant_d) begin
                    acc_rd_d = mem_q[addr_d];
                end else begin
                    cpu_rd_d = mem_q[addr_d];
                end
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 4'd0;
            grant_q   <= 1'b0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= 8'd0;
            cpu_ack_q <= 1'b0;
            acc_ack_q <= 1'b0;
            cpu_rd_q  <= 8'd0;
            acc_rd_q  <= 8'd0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            cpu_ack_q <= cpu_ack_d;
            acc_ack_q <= acc_ack_d;
            cpu_rd_q  <= cpu_rd_d;
            acc_rd_q  <= acc_rd_d;
            busy_q    <= busy_d;
        end
    end

    // Storage is not reset; a reset forces IDLE so no write can land.
    always_ff @(posedge clk) begin
        if (state_q == S_ACK && wr_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign cpu_data_out     = cpu_rd_q;
    assign acc_xram_data_in = acc_rd_q;
    assign cpu_ack          = cpu_ack_q;
    assign acc_xram_ack     = acc_ack_q;
    assign busy             = busy_q;
    assign grant            = grant_q;

endmodule

// File: tb/tb_xram_responder.sv
// Directed bench for xram_responder: three instances with
// WAIT_CYCLES of 1, 0 and 3 share one clock and reset.
module tb_xram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] c_addr [3];
    logic [7:0]  c_din  [3];
    logic [7:0]  c_dout [3];
    logic        c_wr   [3];
    logic        c_stb  [3];
    logic        c_ack  [3];
    logic [15:0] a_addr [3];
    logic [7:0]  a_wdat [3];
    logic [7:0]  a_rdat [3];
    logic        a_wr   [3];
    logic        a_stb  [3];
    logic        a_ack  [3];
    logic        busy   [3];
    logic        grant  [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    xram_responder #(.MEM_AW(12), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst),
        .cpu_addr(c_addr[0]), .cpu_data_in(c_din[0]),
        .cpu_data_out(c_dout[0]), .cpu_wr(c_wr[0]),
        .cpu_stb(c_stb[0]), .cpu_ack(c_ack[0]),
        .acc_xram_addr(a_addr[0]), .acc_xram_data_out(a_wdat[0]),
        .acc_xram_data_in(a_rdat[0]), .acc_xram_wr(a_wr[0]),
        .acc_xram_stb(a_stb[0]), .acc_xram_ack(a_ack[0]),
        .busy(busy[0]), .grant(grant[0])
    );

    xram_responder #(.MEM_AW(12), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst),
        .cpu_addr(c_addr[1]), .cpu_data_in(c_din[1]),
        .cpu_data_out(c_dout[1]), .cpu_wr(c_wr[1]),
        .cpu_stb(c_stb[1]), .cpu_ack(c_ack[1]),
        .acc_xram_addr(a_addr[1]), .acc_xram_data_out(a_wdat[1]),
        .acc_xram_data_in(a_rdat[1]), .acc_xram_wr(a_wr[1]),
        .acc_xram_stb(a_stb[1]), .acc_xram_ack(a_ack[1]),
        .busy(busy[1]), .grant(grant[1])
    );

    xram_responder #(.MEM_AW(12), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst),
        .cpu_addr(c_addr[2]), .cpu_data_in(c_din[2]),
        .cpu_data_out(c_dout[2]), .cpu_wr(c_wr[2]),
        .cpu_stb(c_stb[2]), .cpu_ack(c_ack[2]),
        .acc_xram_addr(a_addr[2]), .acc_xram_data_out(a_wdat[2]),
        .acc_xram_data_in(a_rdat[2]), .acc_xram_wr(a_wr[2]),
        .acc_xram_stb(a_stb[2]), .acc_xram_ack(a_ack[2]),
        .busy(busy[2]), .grant(grant[2])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on instance k, port p (0 = CPU, 1 = accelerator).
    task automatic xfer(input int k, input bit p, input logic [15:0] a,
                        input bit w, input logic [7:0] d,
                        output logic [7:0] r, output int lat);
        bit got;
        if (!p) begin
            c_addr[k] = a; c_wr[k] = w; c_din[k] = d; c_stb[k] = 1'b1;
        end else begin
            a_addr[k] = a; a_wr[k] = w; a_wdat[k] = d; a_stb[k] = 1'b1;
        end
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            lat++;
            got = p ? a_ack[k] : c_ack[k];
        end
        r = p ? a_rdat[k] : c_rdat_sel(k);
        c_stb[k] = 1'b0;
        a_stb[k] = 1'b0;
        if (!got) check("ack_timeout", 32'(got), 32'd1);
    endtask

    function automatic logic [7:0] c_rdat_sel(input int k);
        return c_dout[k];
    endfunction

    initial begin
        logic [7:0] r;
        int         lat;
        int         n;
        int         last;
        int         cyc;
        bit         seen;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            c_addr[k] = '0; c_din[k] = '0; c_wr[k] = 1'b0; c_stb[k] = 1'b0;
            a_addr[k] = '0; a_wdat[k] = '0; a_wr[k] = 1'b0; a_stb[k] = 1'b0;
        end
        repeat (2) tick();
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_grant", 32'(grant[0]), 32'd0);
        check("rst_cack", 32'(c_ack[0]), 32'd0);
        check("rst_aack", 32'(a_ack[0]), 32'd0);
        check("rst_cdout", 32'(c_dout[0]), 32'd0);
        check("rst_adin", 32'(a_rdat[0]), 32'd0);
        rst = 1'b0;
        tick();

        // CPU write then read back, two-cycle ack latency
        xfer(0, 1'b0, 16'h0123, 1'b1, 8'h5a, r, lat);
        check("cpu_wr_lat", 32'(lat), 32'd2);
        tick();
        check("cpu_ack_1cyc", 32'(c_ack[0]), 32'd0);
        xfer(0, 1'b0, 16'h0123, 1'b0, 8'h00, r, lat);
        check("cpu_rd_lat", 32'(lat), 32'd2);
        check("cpu_rd_data", 32'(r), 32'h5a);
        check("cpu_rd_grant", 32'(grant[0]), 32'd0);
        tick();

        // Accelerator 16-byte streaming read
        for (int i = 0; i < 16; i++) begin
            xfer(0, 1'b1, 16'h0200 + 16'(i), 1'b1, 8'h30 + 8'(i), r, lat);
            tick();
        end
        a_addr[0] = 16'h0200; a_wr[0] = 1'b0; a_stb[0] = 1'b1;
        n = 0; last = 0; cyc = 0;
        for (int i = 0; i < 100 && n < 16; i++) begin
            tick();
            cyc++;
            if (a_ack[0]) begin
                check("blk_data", 32'(a_rdat[0]), 32'(8'h30 + 8'(n)));
                if (n > 0) check("blk_gap", 32'(cyc - last), 32'd3);
                last = cyc;
                n++;
                a_addr[0] = 16'h0200 + 16'(n);
                if (n == 16) a_stb[0] = 1'b0;
            end
        end
        a_stb[0] = 1'b0;
        check("blk_count", 32'(n), 32'd16);
        tick();

        // Both ports request continuously
        c_addr[0] = 16'h0300; c_wr[0] = 1'b0; c_stb[0] = 1'b1;
        a_addr[0] = 16'h0301; a_wr[0] = 1'b0; a_stb[0] = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (c_ack[0] || a_ack[0]) begin
`ifdef XRAM_RR_ARB_EN
                check("arb_owner", 32'(a_ack[0]), 32'(n % 2));
`else
                check("arb_owner", 32'(a_ack[0]), 32'd0);
`endif
                check("arb_grant", 32'(grant[0]), 32'(a_ack[0]));
                n++;
            end
        end
        check("arb_count", 32'(n), 32'd4);
        c_stb[0] = 1'b0;
        seen = 1'b0;
        for (lat = 0; lat < 20 && !seen; ) begin
            tick();
            lat++;
            seen = a_ack[0];
        end
        a_stb[0] = 1'b0;
        check("arb_acc_after", 32'(seen), 32'd1);
        check("arb_acc_lat", 32'(lat), 32'd2);
        tick();

        // CPU above limit is ignored; memory unchanged
        xfer(0, 1'b1, 16'h0f05, 1'b1, 8'h12, r, lat);
        tick();
        c_addr[0] = 16'hff05; c_wr[0] = 1'b1; c_din[0] = 8'haa; c_stb[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy[0] || c_ack[0] || a_ack[0]) seen = 1'b1;
        end
        c_stb[0] = 1'b0;
        check("hi_addr_idle", 32'(seen), 32'd0);
        xfer(0, 1'b1, 16'h0f05, 1'b0, 8'h00, r, lat);
        check("hi_addr_mem", 32'(r), 32'h12);
        tick();

        // Address aliasing modulo 4 KiB
        xfer(0, 1'b1, 16'h1010, 1'b1, 8'h77, r, lat);
        tick();
        xfer(0, 1'b0, 16'h0010, 1'b0, 8'h00, r, lat);
        check("alias_rd", 32'(r), 32'h77);
        tick();

        // Reset during WAIT of a write
        xfer(0, 1'b0, 16'h0040, 1'b1, 8'h11, r, lat);
        tick();
        c_addr[0] = 16'h0040; c_wr[0] = 1'b1; c_din[0] = 8'hff; c_stb[0] = 1'b1;
        tick();
        check("rstw_busy_pre", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("rstw_busy", 32'(busy[0]), 32'd0);
        check("rstw_ack", 32'(c_ack[0]), 32'd0);
        tick();
        c_stb[0] = 1'b0;
        rst = 1'b0;
        tick();
        check("rstw_ack_post", 32'(c_ack[0]), 32'd0);
        xfer(0, 1'b0, 16'h0040, 1'b0, 8'h00, r, lat);
        check("rstw_mem", 32'(r), 32'h11);
        tick();

        // Zero wait states
        xfer(1, 1'b1, 16'h0055, 1'b1, 8'h3c, r, lat);
        check("w0_wr_lat", 32'(lat), 32'd1);
        tick();
        xfer(1, 1'b1, 16'h0055, 1'b0, 8'h00, r, lat);
        check("w0_rd_lat", 32'(lat), 32'd1);
        check("w0_rd_data", 32'(r), 32'h3c);
        tick();

        // Three wait states, then an aborted write
        xfer(2, 1'b1, 16'h0066, 1'b1, 8'h9a, r, lat);
        check("w3_lat", 32'(lat), 32'd4);
        tick();
        a_addr[2] = 16'h0066; a_wr[2] = 1'b1; a_wdat[2] = 8'h00; a_stb[2] = 1'b1;
        tick();
        check("abort_busy_pre", 32'(busy[2]), 32'd1);
        tick();
        a_stb[2] = 1'b0;
        tick();
        check("abort_busy", 32'(busy[2]), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (a_ack[2] || busy[2]) seen = 1'b1;
        end
        check("abort_no_ack", 32'(seen), 32'd0);
        xfer(2, 1'b1, 16'h0066, 1'b0, 8'h00, r, lat);
        check("abort_mem", 32'(r), 32'h9a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
